// File: rtl/demux_1to4_reg_pkg.sv
// Shared lane-count and select-width constants for the mux/demux family.
package demux_1to4_reg_pkg;
    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;
endpackage

// File: rtl/demux_1to4_reg_decode.sv
// Combinational 2-to-4 one-hot decoder; bit k is high when sel_i == k.
module demux_1to4_reg_decode
    import demux_1to4_reg_pkg::*;
(
    input  logic [SEL_W-1:0]     sel_i,
    output logic [NUM_LANES-1:0] oh_o
);
    always_comb begin
        oh_o        = '0;
        oh_o[sel_i] = 1'b1;
    end
endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer: steers `in` to the lane chosen by {s1,s0},
// zeroing the other lanes, with a one-hot record of the last routed lane.
module demux_1to4_reg
    import demux_1to4_reg_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in,
    input  logic                 s1,
    input  logic                 s0,
    input  logic                 en,
    output logic [WIDTH-1:0]     d0,
    output logic [WIDTH-1:0]     d1,
    output logic [WIDTH-1:0]     d2,
    output logic [WIDTH-1:0]     d3,
    output logic [NUM_LANES-1:0] sel_oh
);
    logic [SEL_W-1:0]                sel;
    logic [NUM_LANES-1:0]            dec_oh;
    logic [NUM_LANES-1:0][WIDTH-1:0] lane_q, lane_d;
    logic [NUM_LANES-1:0]            oh_q, oh_d;

    assign sel = {s1, s0};

    demux_1to4_reg_decode u_decode (
        .sel_i (sel),
        .oh_o  (dec_oh)
    );

    // The decoded one-hot both gates data into each lane and becomes sel_oh.
    always_comb begin
        lane_d = lane_q;
        oh_d   = oh_q;
        if (en) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_d[k] = dec_oh[k] ? in : '0;
            end
            oh_d = dec_oh;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
            oh_q   <= '0;
        end else begin
            lane_q <= lane_d;
            oh_q   <= oh_d;
        end
    end

    assign d0     = lane_q[0];
    assign d1     = lane_q[1];
    assign d2     = lane_q[2];
    assign d3     = lane_q[3];
    assign sel_oh = oh_q;
endmodule

// File: tb/tb_demux_1to4_reg.sv
// Self-checking bench for demux_1to4_reg: directed plan plus randomized traffic
// checked every cycle against a lane-array reference model.
module tb_demux_1to4_reg;
    localparam int W = 8;

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic         en   = 1'b0;
    logic         s1   = 1'b0;
    logic         s0   = 1'b0;
    logic [W-1:0] in_v = '0;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   sel_oh;

    demux_1to4_reg #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in_v),
        .s1     (s1),
        .s0     (s0),
        .en     (en),
        .d0     (d0),
        .d1     (d1),
        .d2     (d2),
        .d3     (d3),
        .sel_oh (sel_oh)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    // Reference: four lane values and a one-hot, updated by the routing rule.
    logic [W-1:0] m_d [4];
    logic [3:0]   m_oh;
    int           m_sel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) m_d[k] = '0;
            m_oh = 4'b0000;
        end else if (en) begin
            m_sel = 2 * int'(s1) + int'(s0);
            for (int k = 0; k < 4; k++) m_d[k] = (k == m_sel) ? in_v : '0;
            m_oh = 4'(1 << m_sel);
        end
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got {d3,d2,d1,d0,oh}=%h required %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [35:0] outs();
        return {d3, d2, d1, d0, sel_oh};
    endfunction

    always @(negedge clk) begin
        if (cmp_on)
            check("model", outs(), {m_d[3], m_d[2], m_d[1], m_d[0], m_oh});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] v, input logic [1:0] s, input logic e);
        in_v     = v;
        {s1, s0} = s;
        en       = e;
    endtask

    initial begin
        // Reset asserted with no clock edge, inputs set to route in=1 to d3
        #1;
        drive(8'h01, 2'b11, 1'b1);
        rst = 1'b1;
        #2;
        check("rst_async", outs(), 36'h0);
        tick();
        check("rst_hold1", outs(), 36'h0);
        tick();
        check("rst_hold2", outs(), 36'h0);
        cmp_on = 1'b1;
        rst    = 1'b0;

        // Select sweep 00, 10, 01, 11
        drive(8'h01, 2'b00, 1'b1); tick();
        check("sweep_00", outs(), {8'h00, 8'h00, 8'h00, 8'h01, 4'b0001});
        drive(8'h01, 2'b10, 1'b1); tick();
        check("sweep_10", outs(), {8'h00, 8'h01, 8'h00, 8'h00, 4'b0100});
        drive(8'h01, 2'b01, 1'b1); tick();
        check("sweep_01", outs(), {8'h00, 8'h00, 8'h01, 8'h00, 4'b0010});
        drive(8'h01, 2'b11, 1'b1); tick();
        check("sweep_11", outs(), {8'h01, 8'h00, 8'h00, 8'h00, 4'b1000});

        // Zero data still moves sel_oh
        drive(8'h00, 2'b10, 1'b1); tick();
        check("zero_data", outs(), {8'h00, 8'h00, 8'h00, 8'h00, 4'b0100});

        // Hold with en low, then re-enable
        drive(8'h01, 2'b11, 1'b1); tick();
        check("hold_load", outs(), {8'h01, 8'h00, 8'h00, 8'h00, 4'b1000});
        drive(8'h00, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold", outs(), {8'h01, 8'h00, 8'h00, 8'h00, 4'b1000});
        end
        drive(8'h00, 2'b00, 1'b1); tick();
        check("hold_release", outs(), {8'h00, 8'h00, 8'h00, 8'h00, 4'b0001});

        // Wide data and a lane switch on one edge
        drive(8'hA5, 2'b01, 1'b1); tick();
        check("wide_d1", outs(), {8'h00, 8'h00, 8'hA5, 8'h00, 4'b0010});
        drive(8'h3C, 2'b11, 1'b1); tick();
        check("wide_d3", outs(), {8'h3C, 8'h00, 8'h00, 8'h00, 4'b1000});

        // Asynchronous reset pulse between edges
        drive(8'h01, 2'b10, 1'b1); tick();
        check("pre_rst_d2", outs(), {8'h00, 8'h01, 8'h00, 8'h00, 4'b0100});
        #2 rst = 1'b1;
        #1 check("mid_rst", outs(), 36'h0);
        rst = 1'b0;
        drive(8'h5A, 2'b00, 1'b1); tick();
        check("post_rst", outs(), {8'h00, 8'h00, 8'h00, 8'h5A, 4'b0001});

        // Randomized traffic with occasional async reset pulses
        for (int i = 0; i < 400; i++) begin
            drive(W'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 19) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
            tick();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_1to4_reg.md
Name: demux_1to4_reg

Overview:
- Registered 1-to-4 demultiplexer.
- Routes a single data input `in` to one of four outputs `d0`..`d3`, selected by the 2-bit code {s1,s0}.
- All outputs not selected are driven to zero.
- Used as a lane-steering leaf in datapaths; outputs are flopped on `clk` so the block can sit directly on a register boundary.

Parameters:
- WIDTH, 1, bit width of `in` and of each output `d0`..`d3`.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  data to route.
- s1  input  1  select MSB.
- s0  input  1  select LSB.
- en  input  1  update enable; when low, outputs and `sel_oh` hold their values.
- d0  output  WIDTH  lane 0 data; equals `in` when {s1,s0}=00, else 0.
- d1  output  WIDTH  lane 1 data; equals `in` when {s1,s0}=01, else 0.
- d2  output  WIDTH  lane 2 data; equals `in` when {s1,s0}=10, else 0.
- d3  output  WIDTH  lane 3 data; equals `in` when {s1,s0}=11, else 0.
- sel_oh  output  4  one-hot of the last routed lane; bit k corresponds to dk.

Behaviour:
- Reset: asserting `rst` immediately (no clock needed) forces `d0`..`d3` = 0 and `sel_oh` = 4'b0000. They stay there while `rst` is high, including reset asserted mid-operation.
- Select decode: sel = {s1,s0}, with `s1` as the MSB. 00→d0, 01→d1, 10→d2, 11→d3.
- Update rule: on each rising `clk` edge with `rst` low and `en` high:
  - the selected dk ← `in`;
  - the other three outputs ← 0;
  - `sel_oh` ← 1<<sel.
- Hold rule: on a rising edge with `en` low, all outputs and `sel_oh` keep their previous values.
- Latency: exactly one clock from sampled `in`/`s1`/`s0` to outputs. There is no combinational path from inputs to outputs.
- Output invariant: at most one dk can be non-zero at any time. The selected dk may itself be zero when `in` = 0.
- Select changes: a change of {s1,s0} between edges takes effect at the next enabled edge. On that edge the previously selected lane drops to 0 and the new lane takes `in`, with no intermediate state.
- First edge after reset release: behaves like any other edge (update if `en`=1, hold at zero if `en`=0).
- X/unknown on `in` or the selects: no X-propagation handling is required. The bench must drive known values before the first enabled edge.
- No handshake, no back-pressure, no internal state beyond the output registers.

Decomposition:
- Shared package: localparam NUM_LANES = 4 and SEL_W = 2 for reuse by sibling mux/demux blocks.
- Optional sub-module `demux_decode`: a combinational 2-to-4 one-hot decoder. Its output gates the data into each lane register and also feeds `sel_oh`.
- Otherwise a single flat module.

Test Plan:
1. Reset: assert `rst` with `in`=1, sel=11, `en`=1 and no clock edge → d0..d3 = 0 and `sel_oh` = 0000 immediately; they stay 0 across edges while `rst` is high.
2. Sweep, WIDTH=1: `en`=1, `in`=1; sel 00, 10, 01, 11 applied on successive cycles → one cycle later respectively:
   - d0=1, `sel_oh`=0001, others 0;
   - d2=1, `sel_oh`=0100;
   - d1=1, `sel_oh`=0010;
   - d3=1, `sel_oh`=1000.
3. Zero data: `in`=0, sel=10 → all d = 0, `sel_oh`=0100.
4. Hold: route `in`=1 to d3, then set `en`=0 and change sel to 00 with `in`=0 → d3 stays 1 and `sel_oh` stays 1000 for 3 cycles. Re-raise `en` → d0=0, d3=0, `sel_oh`=0001.
5. Wide data, WIDTH=8: `in`=8'hA5, sel=01 → d1=8'hA5, d0/d2/d3=0. Then `in`=8'h3C, sel=11 → d3=8'h3C and d1=0 on the same edge.
6. Async reset mid-stream: `rst` pulsed high between clock edges while d2=1 → outputs go to 0 before the next edge. After release, the next enabled edge routes normally.
